coin_front_end: RTL and testbench
=================================

Name: coin_front_end

Overview:
Upstream stage of the vending-machine controller. It turns the two raw, bouncy coin-sensor lines (5-unit and 10-unit slots) into the clean 2-bit coin code the controller consumes. Coding: 01 = 5-unit, 10 = 10-unit, 00 = no coin. Each coin appears as exactly one cycle of its code, and there is always at least one 00 cycle between successive codes. Per channel, the block provides synchronization, debouncing and rising-edge detection. A 2-entry event FIFO serializes coins that arrive at the same time or close together.

Parameters:
DEB_CYCLES, 4, consecutive cycles a synchronized level must differ from the debounced level before the debounced level follows it (legal range 2..7)
CNT_W, 3, debounce counter width; must hold DEB_CYCLES-1

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
coin5_raw  input  1  raw 5-unit sensor, asynchronous to clk
coin10_raw  input  1  raw 10-unit sensor, asynchronous to clk
coin  output  2  registered coin code to controller (01/10/00)
overflow  output  1  registered one-cycle pulse: a coin event was dropped
busy  output  1  registered; 1 while FIFO non-empty or an issue/gap is in progress

Behaviour:
- Reset (rst=0, asynchronous): all synchronizer flops, debounced levels, counters, FIFO pointers/count, FSM and outputs go to 0. coin=00, overflow=0, busy=0, FSM=IDLE. Deassertion takes effect at the next clk edge.
- Synchronizer: two flops per channel (s1, s2).
- Debounce, per channel, evaluated each edge:
  - if s2 != deb: if cnt == DEB_CYCLES-1, then deb <= s2 and cnt <= 0; otherwise cnt <= cnt+1.
  - if s2 == deb: cnt <= 0.
  - A glitch shorter than DEB_CYCLES sampled cycles never changes deb.
- Event: generated on the edge where deb goes 0->1. A 1->0 transition produces nothing.
- Latency: raw high first sampled at edge k -> deb rises and event pushed at edge k+1+DEB_CYCLES -> coin=code after edge k+2+DEB_CYCLES (FSM idle, FIFO empty) -> coin=00 after edge k+3+DEB_CYCLES.
- FIFO: 2 entries of 2 bits, circular, with a count of 0..2.
  - Same-edge events on both channels: push 01 first, then 10.
  - Push and pop on the same edge are both honoured; occupancy is computed after the pop.
  - An event that finds no free slot is dropped. Older entries are never overwritten. overflow=1 for exactly one cycle per edge on which at least one drop occurred.
- FSM, two states:
  - IDLE: coin is 00. If the FIFO is non-empty, then coin <= head, pop, go to ISSUE.
  - ISSUE: coin holds the code for this one cycle. Next edge: coin <= 00, go to IDLE.
  - Minimum spacing is therefore code, 00, code. A code is never held for 2 cycles and two codes are never adjacent.
- busy = (FIFO count != 0) or (state == ISSUE), registered.
- Mid-operation reset: pending FIFO entries and any partly debounced input are discarded. coin=00 immediately on rst assertion. A raw line still high after reset is re-debounced from 0 and produces one new event.
- Raw line held high indefinitely: exactly one event.

Test Plan:
- Reset: rst=0 with both raw lines toggling -> coin=00, overflow=0, busy=0 throughout. Release rst with raw lines low -> outputs stay 0.
- Single 5-unit coin, DEB_CYCLES=4: coin5_raw rises before edge 0 and is held 10 cycles -> coin=01 only in the cycle after edge 6, 00 after edge 7. No second event after coin5_raw falls.
- Glitch rejection: coin10_raw high for 3 sampled cycles then low -> coin stays 00, busy stays 0. Held for 4 cycles -> exactly one coin=10.
- Simultaneous coins: both raw lines rise on the same edge -> coin sequence 01, 00, 10, 00 on consecutive cycles; busy=1 from push until the 10 cycle ends.
- Overflow: both lines rise together while the FSM is in ISSUE with one entry queued -> one event stored, the newer one dropped. overflow=1 for one cycle. Output sequence contains only the stored codes.
- Reset mid-operation: assert rst while coin=10 with one entry queued -> coin=00 immediately. After release with raw lines low, no further codes are issued.

Source files
------------

// File: rtl/coin_front_end.sv
// Coin sensor front end: sync, debounce, edge detect, 2-deep event FIFO
// and a code/gap issue FSM feeding the vending controller.

module coin_sync_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

module coin_deb_stage #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  output logic rise
);

  logic             deb;
  logic [CNT_W-1:0] cnt;
  logic             hit;

  assign hit  = (s != deb) &&
                (cnt == CNT_W'(DEB_CYCLES - 1));
  // Event fires on the same edge the level flips high.
  assign rise = hit && s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (s != deb) begin
      if (hit) begin
        deb <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

module coin_fifo_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ev5,
  input  logic       ev10,
  input  logic       pop,
  output logic [1:0] head,
  output logic [1:0] count,
  output logic [1:0] count_nxt,
  output logic       drop
);

  logic [1:0][1:0] mem;
  logic            wp;
  logic            rp;
  logic [1:0]      cnt_ap;
  logic [1:0]      free;
  logic            acc5;
  logic            acc10;
  logic            wa10;

  // Room is judged after this edge's pop; the 5 event claims first.
  always_comb begin
    cnt_ap    = count - {1'b0, pop};
    free      = 2'd2 - cnt_ap;
    acc5      = ev5 && (free != 2'd0);
    acc10     = ev10 && (free > {1'b0, acc5});
    drop      = (ev5 && !acc5) || (ev10 && !acc10);
    count_nxt = cnt_ap + {1'b0, acc5} + {1'b0, acc10};
    wa10      = wp ^ acc5;
  end

  assign head = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '0;
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (acc5) mem[wp] <= 2'b01;
      if (acc10) mem[wa10] <= 2'b10;
      wp    <= wp ^ acc5 ^ acc10;
      rp    <= rp ^ pop;
      count <= count_nxt;
    end
  end

endmodule

module coin_front_end #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
  output logic [1:0] coin,
  output logic       overflow,
  output logic       busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic       s5;
  logic       s10;
  logic       rise5;
  logic       rise10;
  logic [1:0] head;
  logic [1:0] fcount;
  logic [1:0] fcount_nxt;
  logic       drop;
  logic       pop;
  logic [0:0] state;
  logic [0:0] state_nxt;

  coin_sync_stage u_sync5 (
    .clk   (clk),
    .rst_n (rst),
    .d     (coin5_raw),
    .q     (s5)
  );

  coin_sync_stage u_sync10 (
    .clk   (clk),
    .rst_n (rst),
    .d     (coin10_raw),
    .q     (s10)
  );

  coin_deb_stage #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_deb5 (
    .clk   (clk),
    .rst_n (rst),
    .s     (s5),
    .rise  (rise5)
  );

  coin_deb_stage #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_deb10 (
    .clk   (clk),
    .rst_n (rst),
    .s     (s10),
    .rise  (rise10)
  );

  coin_fifo_stage u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .ev5       (rise5),
    .ev10      (rise10),
    .pop       (pop),
    .head      (head),
    .count     (fcount),
    .count_nxt (fcount_nxt),
    .drop      (drop)
  );

  assign pop = (state == IDLE) && (fcount != 2'd0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (pop) state_nxt = ISSUE;
      ISSUE: state_nxt = IDLE;
    endcase
  end

  // ISSUE forces the gap cycle: a code is followed by at least one 00.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      coin     <= 2'b00;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      coin     <= pop ? head : 2'b00;
      overflow <= drop;
      busy     <= (fcount_nxt != 2'd0) ||
                  (state_nxt == ISSUE);
    end
  end

endmodule

// File: tb/tb_coin_front_end.sv
// Bench for coin_front_end: directed scenarios plus random sensor
// traffic, compared every cycle to a queue-based reference model.

module tb_coin_front_end;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin5_raw = 1'b0;
  logic       coin10_raw = 1'b0;
  logic [1:0] coin;
  logic       overflow;
  logic       busy;

  int checks = 0;
  int failures = 0;

  coin_front_end #(
    .DEB_CYCLES (DEB),
    .CNT_W      (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coin5_raw  (coin5_raw),
    .coin10_raw (coin10_raw),
    .coin       (coin),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // reference model: raw sample history, run lengths, code queue
  bit h5[$];
  bit h10[$];
  int run[2];
  bit md[2];
  int fq[$];
  bit iss;
  int ecoin;
  bit eovf;
  bit ebusy;

  function automatic void m_reset();
    h5.delete();
    h10.delete();
    run[0] = 0;
    run[1] = 0;
    md[0] = 1'b0;
    md[1] = 1'b0;
    fq.delete();
    iss = 1'b0;
    ecoin = 0;
    eovf = 1'b0;
    ebusy = 1'b0;
  endfunction

  // value the debouncer sees now = raw sampled two edges ago
  function automatic bit m_samp(int ch);
    bit s;
    s = 1'b0;
    if (ch == 0) begin
      if (h5.size() >= 2) s = h5[h5.size() - 2];
      h5.push_back(coin5_raw);
      if (h5.size() > 3) void'(h5.pop_front());
    end else begin
      if (h10.size() >= 2) s = h10[h10.size() - 2];
      h10.push_back(coin10_raw);
      if (h10.size() > 3) void'(h10.pop_front());
    end
    return s;
  endfunction

  function automatic bit m_deb(int ch, bit s);
    if (s == md[ch]) begin
      run[ch] = 0;
      return 1'b0;
    end
    run[ch]++;
    if (run[ch] < DEB) return 1'b0;
    md[ch] = s;
    run[ch] = 0;
    return s;
  endfunction

  function automatic void m_edge();
    bit e5;
    bit e10;
    if (!rst) begin
      m_reset();
      return;
    end
    e5 = m_deb(0, m_samp(0));
    e10 = m_deb(1, m_samp(1));
    ecoin = 0;
    if (iss) iss = 1'b0;
    else if (fq.size() > 0) begin
      ecoin = fq.pop_front();
      iss = 1'b1;
    end
    eovf = 1'b0;
    if (e5) begin
      if (fq.size() < 2) fq.push_back(1);
      else eovf = 1'b1;
    end
    if (e10) begin
      if (fq.size() < 2) fq.push_back(2);
      else eovf = 1'b1;
    end
    ebusy = (fq.size() != 0) || iss;
  endfunction

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
    chk("coin", coin, ecoin);
    chk("overflow", overflow, eovf);
    chk("busy", busy, ebusy);
  endtask

  task automatic run_n(input int n,
                       output int c5, output int c10,
                       output int at5, output int at10,
                       output int nb);
    c5 = 0; c10 = 0; at5 = -1; at10 = -1; nb = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (coin == 2'b01) begin
        c5++;
        if (at5 < 0) at5 = i;
      end
      if (coin == 2'b10) begin
        c10++;
        if (at10 < 0) at10 = i;
      end
      if (busy) nb++;
    end
  endtask

  initial begin
    int c5, c10, a5, a10, nb;
    int d5, d10, b5, b10, nb2;
    int found;
    int hold5, hold10;

    m_reset();
    #1 rst = 1'b0;
    #1;
    chk("rst_coin", coin, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);

    // reset held with toggling sensors
    for (int i = 0; i < 10; i++) begin
      coin5_raw = 1'($urandom_range(0, 1));
      coin10_raw = 1'($urandom_range(0, 1));
      tick();
    end
    coin5_raw = 1'b0;
    coin10_raw = 1'b0;
    rst = 1'b1;
    run_n(6, c5, c10, a5, a10, nb);
    chk("post_rst_codes", c5 + c10, 0);
    chk("post_rst_busy", nb, 0);

    // single 5-unit coin held 10 cycles
    coin5_raw = 1'b1;
    run_n(10, c5, c10, a5, a10, nb);
    coin5_raw = 1'b0;
    run_n(12, d5, d10, b5, b10, nb2);
    chk("single_at", a5, 6);
    chk("single_cnt", c5 + d5, 1);
    chk("single_c10", c10 + d10, 0);

    // glitch of 3 sampled cycles is rejected
    coin10_raw = 1'b1;
    run_n(3, c5, c10, a5, a10, nb);
    coin10_raw = 1'b0;
    run_n(12, d5, d10, b5, b10, nb2);
    chk("glitch3_cnt", c10 + d10, 0);
    chk("glitch3_busy", nb + nb2, 0);

    // 4 sampled cycles is accepted once
    coin10_raw = 1'b1;
    run_n(4, c5, c10, a5, a10, nb);
    coin10_raw = 1'b0;
    run_n(12, d5, d10, b5, b10, nb2);
    chk("glitch4_cnt", c10 + d10, 1);

    // simultaneous coins: 01, 00, 10, 00
    coin5_raw = 1'b1;
    coin10_raw = 1'b1;
    run_n(14, c5, c10, a5, a10, nb);
    chk("simul_at5", a5, 6);
    chk("simul_at10", a10, 8);
    chk("simul_cnt", c5 * 10 + c10, 11);
    chk("simul_busy", nb, 4);
    coin5_raw = 1'b0;
    coin10_raw = 1'b0;
    run_n(12, c5, c10, a5, a10, nb);
    chk("simul_fall", c5 + c10, 0);

    // line held high for a long time: one event
    coin5_raw = 1'b1;
    run_n(40, c5, c10, a5, a10, nb);
    chk("hold_cnt", c5, 1);
    coin5_raw = 1'b0;
    run_n(12, c5, c10, a5, a10, nb);

    // staggered pair, reset while 10 is out and 01 is queued
    coin10_raw = 1'b1;
    tick();
    coin5_raw = 1'b1;
    found = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (coin == 2'b10) begin
        found = i;
        break;
      end
    end
    chk("rstmid_at", found, 5);
    chk("rstmid_q", fq.size(), 1);
    rst = 1'b0;
    coin5_raw = 1'b0;
    coin10_raw = 1'b0;
    m_reset();
    #1;
    chk("rstmid_coin", coin, 0);
    chk("rstmid_busy", busy, 0);
    tick();
    tick();
    rst = 1'b1;
    run_n(15, c5, c10, a5, a10, nb);
    chk("rstmid_after", c5 + c10, 0);

    // random sensor traffic with occasional async resets
    hold5 = 0;
    hold10 = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (hold5 == 0) begin
        coin5_raw = ~coin5_raw;
        hold5 = $urandom_range(1, 9);
      end
      if (hold10 == 0) begin
        coin10_raw = ~coin10_raw;
        hold10 = $urandom_range(1, 9);
      end
      hold5--;
      hold10--;
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0;
        m_reset();
        #1;
        chk("rnd_rst_coin", coin, 0);
        tick();
        tick();
        rst = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
